// File: rtl/floppy_id_search.sv
// Controller-side ID search over the drive's byte-clocked sector stream: rebuilds the
// 6-byte ID field with its CRC, matches a requested sector and counts its data bytes.
module floppy_id_search #(
    parameter int MAX_REVS = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dclk_en,
    input  logic        sector_hdr,
    input  logic        sector_data,
    input  logic        index,
    input  logic        ready,
    input  logic [6:0]  track,
    input  logic [4:0]  sector,
    input  logic        side,
    input  logic [10:0] sector_len,
    input  logic        fm,
    input  logic        search_start,
    input  logic [6:0]  want_track,
    input  logic [4:0]  want_sector,
    input  logic        want_side,
    input  logic        check_side,
    output logic [7:0]  hdr_byte,
    output logic        hdr_byte_en,
    output logic        busy,
    output logic        id_match,
    output logic        data_en,
    output logic [10:0] data_idx,
    output logic        done,
    output logic        rnf
);

    typedef enum logic [1:0] {IDLE, WAIT_HDR, CHECK, DATA} state_t;

    localparam int          REV_W      = $clog2(MAX_REVS + 1);
    localparam logic [15:0] PRESET_MFM = 16'hB230;
    localparam logic [15:0] PRESET_FM  = 16'hEF21;

    state_t             state_q;
    logic               hdrPrev_q;
    logic               dataPrev_q;
    logic               indexPrev_q;
    logic [2:0]         hb_q;
    logic               hdrDone_q;
    logic [15:0]        crc_q;
    logic               armed_q;
    logic [REV_W-1:0]   revCnt_q;
    logic [10:0]        count_q;
    logic [7:0]         hdrByte_q;
    logic               hdrByteEn_q;
    logic               busy_q;
    logic               idMatch_q;
    logic               dataEn_q;
    logic [10:0]        dataIdx_q;
    logic               done_q;
    logic               rnf_q;

    logic               hdrRise;
    logic               dataFall;
    logic               indexRise;
    logic               hdrStrobe;
    logic               hb5Strobe;
    logic               idHit;
    logic [2:0]         hbEff;
    logic [15:0]        crcEff;
    logic [1:0]         sizeCode;
    logic [7:0]         idByte;
    logic [15:0]        crc_d;

    function automatic logic [15:0] crcUpdate(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    // A byte strobed in the same cycle as the header rising edge is treated as hb0.
    assign hdrRise   = sector_hdr & ~hdrPrev_q;
    assign dataFall  = dataPrev_q & ~sector_data;
    assign indexRise = index & ~indexPrev_q;
    assign hbEff     = hdrRise ? 3'd0 : hb_q;
    assign crcEff    = hdrRise ? (fm ? PRESET_FM : PRESET_MFM) : crc_q;
    assign hdrStrobe = dclk_en & sector_hdr & (hdrRise | ~hdrDone_q);
    assign hb5Strobe = hdrStrobe & (hbEff == 3'd5);
    assign idHit     = (track == want_track) && (sector == want_sector) &&
                       (!check_side || (side == want_side));

    always_comb begin
        sizeCode = 2'd2;
        case (sector_len)
            11'd128:  sizeCode = 2'd0;
            11'd256:  sizeCode = 2'd1;
            11'd512:  sizeCode = 2'd2;
            11'd1024: sizeCode = 2'd3;
            default:  sizeCode = 2'd2;
        endcase
    end

    always_comb begin
        idByte = 8'h00;
        case (hbEff)
            3'd0:    idByte = {1'b0, track};
            3'd1:    idByte = {7'b0, side};
            3'd2:    idByte = {3'b0, sector};
            3'd3:    idByte = {6'b0, sizeCode};
            3'd4:    idByte = crcEff[15:8];
            default: idByte = crcEff[7:0];
        endcase
        crc_d = crcUpdate(crcEff, idByte);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hdrPrev_q   <= 1'b0;
            hb_q        <= 3'd0;
            hdrDone_q   <= 1'b0;
            crc_q       <= PRESET_MFM;
            hdrByte_q   <= 8'h00;
            hdrByteEn_q <= 1'b0;
        end else begin
            hdrPrev_q   <= sector_hdr;
            hdrByteEn_q <= 1'b0;
            if (hdrRise) begin
                hb_q      <= 3'd0;
                hdrDone_q <= 1'b0;
                crc_q     <= fm ? PRESET_FM : PRESET_MFM;
            end
            if (hdrStrobe) begin
                hdrByte_q   <= idByte;
                hdrByteEn_q <= 1'b1;
                if (hbEff < 3'd4) begin
                    crc_q <= crc_d;
                end
                if (hbEff == 3'd5) begin
                    hdrDone_q <= 1'b1;
                end else begin
                    hb_q <= hbEff + 3'd1;
                end
            end
        end
    end

    // Search FSM; loss of ready outranks every other event, so rnf suppresses id_match/done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            dataPrev_q  <= 1'b0;
            indexPrev_q <= 1'b0;
            armed_q     <= 1'b0;
            revCnt_q    <= '0;
            count_q     <= 11'd0;
            busy_q      <= 1'b0;
            idMatch_q   <= 1'b0;
            dataEn_q    <= 1'b0;
            dataIdx_q   <= 11'd0;
            done_q      <= 1'b0;
            rnf_q       <= 1'b0;
        end else begin
            dataPrev_q  <= sector_data;
            indexPrev_q <= index;
            idMatch_q   <= 1'b0;
            dataEn_q    <= 1'b0;
            done_q      <= 1'b0;
            rnf_q       <= 1'b0;
            if ((state_q != IDLE) && !ready) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                rnf_q   <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (search_start) begin
                            state_q  <= WAIT_HDR;
                            busy_q   <= 1'b1;
                            armed_q  <= 1'b0;
                            revCnt_q <= '0;
                        end
                    end
                    WAIT_HDR: begin
                        if (indexRise && (revCnt_q == REV_W'(MAX_REVS - 1))) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            rnf_q   <= 1'b1;
                        end else begin
                            if (indexRise) begin
                                revCnt_q <= revCnt_q + REV_W'(1);
                            end
                            if (hdrRise) begin
                                armed_q <= 1'b1;
                            end
                            if (hb5Strobe && armed_q) begin
                                state_q <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        if (idHit) begin
                            idMatch_q <= 1'b1;
                            count_q   <= 11'd0;
                            state_q   <= DATA;
                        end else begin
                            state_q <= WAIT_HDR;
                        end
                    end
                    DATA: begin
                        if (dataFall) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            rnf_q   <= 1'b1;
                        end else if (dclk_en && sector_data) begin
                            dataEn_q  <= 1'b1;
                            dataIdx_q <= count_q;
                            if (count_q == (sector_len - 11'd1)) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end else begin
                                count_q <= count_q + 11'd1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign hdr_byte    = hdrByte_q;
    assign hdr_byte_en = hdrByteEn_q;
    assign busy        = busy_q;
    assign id_match    = idMatch_q;
    assign data_en     = dataEn_q;
    assign data_idx    = dataIdx_q;
    assign done        = done_q;
    assign rnf         = rnf_q;

endmodule

// File: tb/tb_floppy_id_search.sv
// Scoreboard bench for floppy_id_search: a drive model pushes expected ID bytes and
// search events when it drives the stream; a negedge monitor pops and compares them.
module tb_floppy_id_search;

    localparam int          MAX_REVS = 5;
    localparam logic [31:0] EV_MATCH = 32'h0008_0000;
    localparam logic [31:0] EV_DATA  = 32'h0004_0000;
    localparam logic [31:0] EV_DONE  = 32'h0002_0000;
    localparam logic [31:0] EV_RNF   = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dclk_en, sector_hdr, sector_data, index, ready;
    logic [6:0]  track;
    logic [4:0]  sector;
    logic        side;
    logic [10:0] sector_len;
    logic        fm, search_start;
    logic [6:0]  want_track;
    logic [4:0]  want_sector;
    logic        want_side, check_side;
    logic [7:0]  hdr_byte;
    logic        hdr_byte_en, busy, id_match, data_en, done, rnf;
    logic [10:0] data_idx;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  hdrQ[$];
    logic [31:0] evtQ[$];
    logic [31:0] obs;
    int          order[9] = '{9, 1, 2, 3, 4, 5, 6, 7, 8};

    floppy_id_search #(.MAX_REVS(MAX_REVS)) dut (
        .clk(clk), .reset_n(reset_n), .dclk_en(dclk_en), .sector_hdr(sector_hdr),
        .sector_data(sector_data), .index(index), .ready(ready), .track(track),
        .sector(sector), .side(side), .sector_len(sector_len), .fm(fm),
        .search_start(search_start), .want_track(want_track), .want_sector(want_sector),
        .want_side(want_side), .check_side(check_side), .hdr_byte(hdr_byte),
        .hdr_byte_en(hdr_byte_en), .busy(busy), .id_match(id_match), .data_en(data_en),
        .data_idx(data_idx), .done(done), .rnf(rnf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Bit-serial CRC-16/CCITT, data bit fed against the register MSB.
    function automatic logic [15:0] swCrc(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ b[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    function automatic logic [7:0] expSize(input int len);
        if (len == 128) return 8'd0;
        if (len == 256) return 8'd1;
        if (len == 1024) return 8'd3;
        return 8'd2;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic driveHeader(input logic [6:0] trk, input logic sd, input logic [4:0] sec,
                               input int startAt, input bit expMatch);
        logic [7:0]  id[6];
        logic [15:0] c;
        c = 16'hFFFF;
        if (!fm) begin
            for (int k = 0; k < 3; k++) c = swCrc(c, 8'hA1);
        end
        c = swCrc(c, 8'hFE);
        id[0] = {1'b0, trk};
        id[1] = {7'b0, sd};
        id[2] = {3'b0, sec};
        id[3] = expSize(int'(sector_len));
        for (int k = 0; k < 4; k++) c = swCrc(c, id[k]);
        id[4] = c[15:8];
        id[5] = c[7:0];
        track = trk;
        side = sd;
        sector = sec;
        sector_hdr = 1'b1;
        tick(2);
        for (int k = 0; k < 6; k++) begin
            if (k == startAt) begin
                search_start = 1'b1;
                tick(1);
                search_start = 1'b0;
            end
            hdrQ.push_back(id[k]);
            if (k == 5 && expMatch) evtQ.push_back(EV_MATCH);
            dclk_en = 1'b1;
            tick(1);
            dclk_en = 1'b0;
            tick(1);
        end
        tick(2);
        sector_hdr = 1'b0;
    endtask

    task automatic driveData(input int nBytes, input bit expMatch, input int abortAt);
        tick(2);
        sector_data = 1'b1;
        tick(1);
        for (int i = 0; i < nBytes; i++) begin
            if (expMatch) begin
                if (i == 0) checkOutput("busyInData", busy, 1);
                evtQ.push_back((i == nBytes - 1) ? (EV_DATA | EV_DONE | 32'(i)) : (EV_DATA | 32'(i)));
            end
            dclk_en = 1'b1;
            tick(1);
            dclk_en = 1'b0;
            if (i == abortAt) begin
                ready = 1'b0;
                evtQ.push_back(EV_RNF);
                tick(1);
                ready = 1'b1;
                search_start = 1'b1;
                tick(1);
                search_start = 1'b0;
                checkOutput("restartBusy", busy, 1);
                ready = 1'b0;
                evtQ.push_back(EV_RNF);
                tick(1);
                ready = 1'b1;
                tick(2);
                checkOutput("abortIdle", busy, 0);
                break;
            end
            tick(1);
        end
        if (expMatch && abortAt < 0) checkOutput("busyAfterDone", busy, 0);
        sector_data = 1'b0;
        tick(2);
    endtask

    task automatic applyStimulus(input logic [6:0] trk, input logic sd, input logic [4:0] sec,
                                 input int nBytes, input bit expMatch, input int abortAt, input int startAt);
        driveHeader(trk, sd, sec, startAt, expMatch);
        driveData(nBytes, expMatch, abortAt);
    endtask

    task automatic driveRev(input logic [6:0] trk, input int matchSec, input int nSec, input bit rnfHere);
        if (rnfHere) evtQ.push_back(EV_RNF);
        index = 1'b1;
        tick(3);
        index = 1'b0;
        tick(2);
        for (int s = 0; s < nSec; s++) begin
            applyStimulus(trk, 1'b0, 5'(order[s]), int'(sector_len), order[s] == matchSec, -1, -1);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (hdr_byte_en) begin
                if (hdrQ.size() == 0) checkOutput("hdrExtra", 32'(hdr_byte), 32'hFFFF_FFFF);
                else checkOutput("hdrByte", 32'(hdr_byte), 32'(hdrQ.pop_front()));
            end
            if (id_match || data_en || done || rnf) begin
                obs = {12'h0, id_match, data_en, done, rnf, 5'h0, data_en ? data_idx : 11'h0};
                if (evtQ.size() == 0) checkOutput("evtExtra", obs, 32'hFFFF_FFFF);
                else checkOutput("event", obs, evtQ.pop_front());
            end
        end
    end

    initial begin
        #3_000_000;
        total++;
        bad++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int lens[4] = '{128, 512, 1024, 300};
        reset_n = 1'b0;
        dclk_en = 1'b0; sector_hdr = 1'b0; sector_data = 1'b0; index = 1'b0; ready = 1'b1;
        track = '0; sector = '0; side = 1'b0; sector_len = 11'd256; fm = 1'b0;
        search_start = 1'b0; want_track = '0; want_sector = '0; want_side = 1'b0; check_side = 1'b1;
        tick(3);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstHdrEn", hdr_byte_en, 0);
        checkOutput("rstHdrByte", hdr_byte, 0);
        checkOutput("rstMatch", id_match, 0);
        checkOutput("rstDataEn", data_en, 0);
        checkOutput("rstDataIdx", data_idx, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstRnf", rnf, 0);
        reset_n = 1'b1;
        tick(2);

        $display("[TB] header content, MFM and FM presets, size codes");
        applyStimulus(7'd0, 1'b0, 5'd1, 4, 1'b0, -1, -1);
        fm = 1'b1;
        applyStimulus(7'd0, 1'b0, 5'd1, 4, 1'b0, -1, -1);
        fm = 1'b0;
        foreach (lens[k]) begin
            sector_len = 11'(lens[k]);
            applyStimulus(7'h55, 1'b1, 5'h1A, 0, 1'b0, -1, -1);
        end

        $display("[TB] match on 4th sector of the revolution");
        sector_len = 11'd256;
        want_track = 7'd5; want_sector = 5'd3; want_side = 1'b0; check_side = 1'b1;
        search_start = 1'b1;
        tick(1);
        search_start = 1'b0;
        checkOutput("startBusy", busy, 1);
        driveRev(7'd5, 3, 9, 1'b0);

        $display("[TB] record not found");
        sector_len = 11'd128;
        want_sector = 5'd12;
        search_start = 1'b1;
        index = 1'b1;
        tick(1);
        search_start = 1'b0;
        tick(2);
        index = 1'b0;
        tick(2);
        checkOutput("rnfBusy", busy, 1);
        for (int r = 1; r <= MAX_REVS; r++) begin
            driveRev(7'd5, 12, (r == MAX_REVS) ? 1 : 9, r == MAX_REVS);
        end
        checkOutput("rnfIdle", busy, 0);

        $display("[TB] abort on ready loss");
        sector_len = 11'd256;
        want_sector = 5'd3;
        search_start = 1'b1;
        tick(1);
        search_start = 1'b0;
        applyStimulus(7'd5, 1'b0, 5'd3, 256, 1'b1, 40, -1);

        $display("[TB] search started mid-header");
        sector_len = 11'd128;
        check_side = 1'b0;
        want_side = 1'b1;
        applyStimulus(7'd5, 1'b0, 5'd3, 128, 1'b0, -1, 2);
        checkOutput("midStillBusy", busy, 1);
        driveRev(7'd5, 3, 9, 1'b0);

        $display("[TB] reset during search");
        want_sector = 5'd20;
        search_start = 1'b1;
        tick(1);
        search_start = 1'b0;
        checkOutput("preResetBusy", busy, 1);
        reset_n = 1'b0;
        tick(1);
        checkOutput("midResetBusy", busy, 0);
        checkOutput("midResetRnf", rnf, 0);
        reset_n = 1'b1;
        tick(4);

        checkOutput("hdrQEmpty", hdrQ.size(), 0);
        checkOutput("evtQEmpty", evtQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
